// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for uart_rx and the future uart_tx
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Data is zero-extended to 9 bits so one helper covers every NB_DATA from 5 to 9.
    function automatic logic calc_parity(input logic [8:0] i_d, input logic i_odd);
        return (^i_d) ^ i_odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser, resets to 1 (line idle level)
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver; UART_RX_PARITY_EN adds a parity bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic               i_tick,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int SW = $clog2(SB_TICK) + 1;
    localparam int NW = $clog2(NB_DATA);

    logic               w_rx_s;
    logic               r_rx_prev;
    uart_state_t        r_state;
    logic [SW-1:0]      r_s;
    logic [NW-1:0]      r_n;
    logic [NB_DATA-1:0] r_shift;
    logic [NB_DATA-1:0] r_data;
    logic               r_rx_done;
    logic               r_frame_err;
    logic               r_parity_err;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bit;
`endif

    sync_2ff u_sync_rx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= w_rx_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_rx_done    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
`endif
        end else begin
            r_rx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Edge detect, not level, so a held-low break cannot re-trigger.
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: begin
                    if (i_tick) begin
                        if (r_s == SW'(MID_TICK)) begin
                            r_s <= '0;
                            r_n <= '0;
                            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_tick) begin
                        if (r_s == SW'(OVERSAMPLE - 1)) begin
                            r_s     <= '0;
                            r_shift <= {w_rx_s, r_shift[NB_DATA-1:1]};
                            if (r_n == NW'(NB_DATA - 1)) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (i_tick) begin
                        if (r_s == SW'(OVERSAMPLE - 1)) begin
                            r_s       <= '0;
                            r_par_bit <= w_rx_s;
                            r_state   <= ST_STOP;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (i_tick) begin
                        if (r_s == SW'(SB_TICK - 1)) begin
                            // Errored frames are still delivered; downstream decides on discard.
                            r_s         <= '0;
                            r_data      <= r_shift;
                            r_frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= r_par_bit
                                            != calc_parity(9'(r_shift), 1'(PARITY_ODD));
`else
                            r_parity_err <= 1'b0;
`endif
                            r_rx_done   <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_s     <= '0;
                end
            endcase
        end
    end

    assign o_data       = r_data;
    assign o_rx_done    = r_rx_done;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_tick = 1'b0;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_parity_err;

    int total = 0;
    int bad   = 0;

    int         done_cnt = 0;
    logic [7:0] cap_data [64];
    logic       cap_fe   [64];
    logic       cap_pe   [64];

    uart_rx #(.NB_DATA(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx         (i_rx),
        .i_tick       (i_tick),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        forever begin
            repeat (3) @(negedge i_clk);
            i_tick = 1'b1;
            @(negedge i_clk);
            i_tick = 1'b0;
        end
    end

    always @(negedge i_clk) begin
        if (o_rx_done && done_cnt < 64) begin
            cap_data[done_cnt] = o_data;
            cap_fe[done_cnt]   = o_frame_err;
            cap_pe[done_cnt]   = o_parity_err;
            done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge i_clk); while (!i_tick);
        end
        #1;
    endtask

    task automatic send_bit(input logic b, input int nticks);
        i_rx = b;
        wait_ticks(nticks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        send_bit(par, 16);
`endif
        send_bit(stop, 16);
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [7:0] exp_d,
                               input logic exp_fe, input logic exp_pe);
        check({tag, "_data"}, 32'(cap_data[idx]), 32'(exp_d));
        check({tag, "_ferr"}, 32'(cap_fe[idx]), 32'(exp_fe));
        check({tag, "_perr"}, 32'(cap_pe[idx]), 32'(exp_pe));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (5) @(negedge i_clk);
        check("rst_data", 32'(o_data), 32'h00);
        check("rst_done", 32'(o_rx_done), 32'h0);
        check("rst_ferr", 32'(o_frame_err), 32'h0);
        check("rst_perr", 32'(o_parity_err), 32'h0);
        i_reset = 1'b0;
        send_bit(1'b1, 32);

        // 1: clean 0xA5
        base = done_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_bit(1'b1, 32);
        check("t1_count", 32'(done_cnt - base), 32'd1);
        check_frame("t1", base, 8'hA5, 1'b0, 1'b0);

        // 2: short low glitch rejected
        base = done_cnt;
        send_bit(1'b0, 4);
        send_bit(1'b1, 48);
        check("t2_count", 32'(done_cnt - base), 32'd0);
        check("t2_hold", 32'(o_data), 32'hA5);

        // 3: 0x3C with stop low, then line held low
        base = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        check("t3_count", 32'(done_cnt - base), 32'd1);
        check_frame("t3", base, 8'h3C, 1'b1, 1'b0);
        send_bit(1'b0, 48);
        check("t3_break", 32'(done_cnt - base), 32'd1);
        check("t3_ferr_held", 32'(o_frame_err), 32'h1);
        send_bit(1'b1, 32);
        check("t3_release", 32'(done_cnt - base), 32'd1);

        // 4: back-to-back 0x00, 0xFF
        base = done_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_bit(1'b1, 32);
        check("t4_count", 32'(done_cnt - base), 32'd2);
        check_frame("t4a", base, 8'h00, 1'b0, 1'b0);
        check_frame("t4b", base + 1, 8'hFF, 1'b0, 1'b1 & 1'b0);

        // 5: reset during data bit 3 of 0x5A
        base = done_cnt;
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        i_rx = 1'b1;
        wait_ticks(8);
        @(negedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check("t5_rst_data", 32'(o_data), 32'h00);
        check("t5_rst_done", 32'(o_rx_done), 32'h0);
        check("t5_rst_ferr", 32'(o_frame_err), 32'h0);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        send_bit(1'b1, 48);
        check("t5_abort", 32'(done_cnt - base), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        send_bit(1'b1, 32);
        check("t5_count", 32'(done_cnt - base), 32'd1);
        check_frame("t5", base, 8'h5A, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity; 0x01 needs parity bit 1
        base = done_cnt;
        send_frame(8'h01, 1'b1, 1'b0);
        send_bit(1'b1, 32);
        send_frame(8'h01, 1'b1, 1'b1);
        send_bit(1'b1, 32);
        check("t6_count", 32'(done_cnt - base), 32'd2);
        check_frame("t6_bad", base, 8'h01, 1'b0, 1'b1);
        check_frame("t6_good", base + 1, 8'h01, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
